// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned REG_ZERO          = 0;

  typedef struct packed {
    logic [DEF_ADDRESS_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } wb_req_t;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_pend_queue.sv
// Ordered pending-writeback FIFO with per-entry live bits, address kill and
// a combinational pending-write query.
module wb_pend_queue
  import rf_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ADDRESS_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0]    push_data,
  input  logic                     pop,
  input  logic                     kill,
  input  logic [ADDRESS_WIDTH-1:0] kill_addr,
  input  logic [ADDRESS_WIDTH-1:0] q_addr,
  output logic                     q_pending,
  output logic [ADDRESS_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0]    head_data,
  output logic                     head_live,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0]         live_q, live_d;
  logic [DEPTH-1:0]         in_queue;
  logic [PTR_W-1:0]         head_q, tail_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     push_live;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign head_live = live_q[head_q];

  // x0 results are stored dead; a same-cycle kill also covers the incoming entry,
  // since the B result is older than the granted A write in program order.
  assign push_live = (push_addr != ADDRESS_WIDTH'(REG_ZERO)) &&
                     !(kill && (kill_addr == push_addr));

  always_comb begin
    in_queue = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset = PTR_W'(i) - head_q;
      if (CNT_W'(offset) < count_q) in_queue[i] = 1'b1;
    end
  end

  always_comb begin
    live_d = live_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill && in_queue[i] && (addr_q[i] == kill_addr)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = push_live;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    q_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live_q[i] && in_queue[i] && (addr_q[i] == q_addr)) q_pending = 1'b1;
    end
    if (q_addr == ADDRESS_WIDTH'(REG_ZERO)) q_pending = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      live_q  <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_W'(1);
      if (pop)  head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      live_q  <= live_d;
    end
  end

  // Payload needs no reset: an entry is only consumed while its live bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between pipeline writeback (A) and a
// queued long-latency result stream (B), with starvation-bounded drain.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_data,
  input  logic [ADDRESS_WIDTH-1:0] q_addr,
  output logic                     q_pending,
  output logic                     wb_we,
  output logic [ADDRESS_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]    wb_data
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t state_q, state_d;
  logic [STARVE_W-1:0]      starve_q, starve_d;
  logic                     wb_we_q, wb_we_d;
  logic [ADDRESS_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;

  logic                     q_empty, q_full, head_live;
  logic [ADDRESS_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0]    head_data;
  logic                     a_grant, pop, push;

  assign a_ready = (state_q == NORMAL);
  assign b_ready = !q_full;
  assign push    = b_valid && !q_full;
  assign a_grant = (state_q == NORMAL) && a_valid;
  // In FORCE a_grant is low, so the head drains whenever the queue is non-empty.
  assign pop     = !q_empty && !a_grant;

  wb_pend_queue #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_addr (b_addr),
    .push_data (b_data),
    .pop       (pop),
    .kill      (a_grant),
    .kill_addr (a_addr),
    .q_addr    (q_addr),
    .q_pending (q_pending),
    .head_addr (head_addr),
    .head_data (head_data),
    .head_live (head_live),
    .empty     (q_empty),
    .full      (q_full)
  );

  always_comb begin
    if (pop || q_empty) begin
      starve_d = '0;
    end else if (a_grant && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STARVE_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_comb begin
    state_d = NORMAL;
    if ((state_q == NORMAL) && (starve_d == STARVE_W'(STARVE_LIMIT))) state_d = FORCE;
  end

  // Address/data only move on a real write so idle and suppressed cycles hold them.
  always_comb begin
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (a_grant) begin
      if (a_addr != ADDRESS_WIDTH'(REG_ZERO)) begin
        wb_we_d   = 1'b1;
        wb_addr_d = a_addr;
        wb_data_d = a_data;
      end
    end else if (pop && head_live) begin
      wb_we_d   = 1'b1;
      wb_addr_d = head_addr;
      wb_data_d = head_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NORMAL;
      starve_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we   = wb_we_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule
